// File: rtl/ks_seq_pkg.sv
// Shared types for the multi-word Kogge-Stone sequencer.
// Holds the FSM state encoding and the limb width.
package ks_seq_pkg;

  localparam int LIMB_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_CINC = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    ADD  = S_ADD,
    CINC = S_CINC,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/kogge_stone_32.sv
// 32-bit Kogge-Stone parallel-prefix adder, no carry-in.
// Ports: a, b (addends), sum (a+b mod 2^32), cout (carry out).
module kogge_stone_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);

  logic [5:0][31:0] g;
  logic [5:0][31:0] p;

  always_comb begin
    g = '0;
    p = '0;
    g[0] = a & b;
    p[0] = a ^ b;
    for (int l = 1; l < 6; l++) begin
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << (l - 1))) begin
          g[l][i] = g[l-1][i] |
                    (p[l-1][i] & g[l-1][i - (1 << (l - 1))]);
          p[l][i] = p[l-1][i] & p[l-1][i - (1 << (l - 1))];
        end else begin
          g[l][i] = g[l-1][i];
          p[l][i] = p[l-1][i];
        end
      end
    end
  end

  // g[5][i] is the carry out of bit i
  assign sum  = p[0] ^ {g[5][30:0], 1'b0};
  assign cout = g[5][31];

endmodule

// File: rtl/ks32_multiword_seq.sv
// Multi-word add/sub that reuses one 32-bit adder per limb, LSB first.
// Ports: in_valid/in_ready/op_sub/a/b in, out_valid/out_ready/result/cout out.
module ks32_multiword_seq
  import ks_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int IDXW  = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op_sub,
  input  logic [WORDS*32-1:0]   a,
  input  logic [WORDS*32-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORDS*32-1:0]   result,
  output logic                  cout
);

  localparam int W = WORDS * LIMB_W;

  state_t              state_q, state_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                sub_q, sub_d;
  logic [W-1:0]        a_q, a_d;
  logic [W-1:0]        b_q, b_d;
  logic [W-1:0]        r_q, r_d;
  logic [LIMB_W-1:0]   tmp_q, tmp_d;
  logic                c1_q, c1_d;

  logic [LIMB_W-1:0]   ks_a, ks_b, ks_sum;
  logic                ks_cout;
  logic                last;

  assign last = (idx_q == IDXW'(WORDS - 1));

  // Adder input mux: CINC adds 1 to the held limb sum,
  // otherwise the current limb pair (b inverted for subtract).
  always_comb begin
    ks_a = a_q[idx_q*LIMB_W +: LIMB_W];
    ks_b = b_q[idx_q*LIMB_W +: LIMB_W] ^ {LIMB_W{sub_q}};
    if (state_q == CINC) begin
      ks_a = tmp_q;
      ks_b = LIMB_W'(1);
    end
  end

  kogge_stone_32 u_add (
    .a    (ks_a),
    .b    (ks_b),
    .sum  (ks_sum),
    .cout (ks_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    tmp_d   = tmp_q;
    c1_d    = c1_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        tmp_d = ks_sum;
        c1_d  = ks_cout;
        if (carry_q) begin
          state_d = CINC;
        end else begin
          r_d[idx_q*LIMB_W +: LIMB_W] = ks_sum;
          carry_d = ks_cout;
          if (last) state_d = DONE;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      CINC: begin
        r_d[idx_q*LIMB_W +: LIMB_W] = ks_sum;
        // at most one of these is set; OR is safe
        carry_d = c1_q | ks_cout;
        if (last) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      tmp_q   <= '0;
      c1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      tmp_q   <= tmp_d;
      c1_q    <= c1_d;
    end
  end

  // Partial limbs never leave the block
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? r_q : '0;
  assign cout      = out_valid & carry_q;

endmodule

// File: tb/tb_ks32_multiword_seq.sv
// Scoreboard bench for ks32_multiword_seq with WORDS=4.
// Checks results, carry, latency, backpressure and async reset.
module tb_ks32_multiword_seq;

  localparam int WORDS = 4;
  localparam int W = WORDS * 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          op_sub = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          cout;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  ks32_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: wide arithmetic; a limb needs an extra pass
  // whenever a carry enters it (recovered from sum^a^b).
  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic s);
    exp_t e;
    logic [W:0] full;
    logic [W-1:0] yy, cv;
    int n;
    yy = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, s};
    e.r = full[W-1:0];
    e.c = full[W];
    cv = full[W-1:0] ^ x ^ yy;
    n = s ? 1 : 0;
    for (int i = 1; i < WORDS; i++) n += cv[32*i] ? 1 : 0;
    e.lat = WORDS + n + 1;
    return e;
  endfunction

  task automatic run_op(input string nm,
                        input logic [W-1:0] x,
                        input logic [W-1:0] y,
                        input logic s,
                        input int bp);
    exp_t e;
    int n;
    logic [W-1:0] hold_r;
    logic hold_c;
    sb.push_back(model(x, y, s));
    chk({nm, "_idle_rdy"}, W'(in_ready), W'(1));
    in_valid = 1'b1;
    a = x;
    b = y;
    op_sub = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    if (!out_valid) begin
      chk({nm, "_timeout"}, W'(out_valid), W'(1));
      return;
    end
    chk({nm, "_lat"}, W'(n + 1), W'(e.lat));
    chk({nm, "_res"}, result, e.r);
    chk({nm, "_cout"}, W'(cout), W'(e.c));
    hold_r = result;
    hold_c = cout;
    for (int k = 0; k < bp; k++) begin
      if (k == 0) begin
        in_valid = 1'b1;
        a = '1;
        b = '1;
        op_sub = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      chk({nm, "_bp_vld"}, W'(out_valid), W'(1));
      chk({nm, "_bp_res"}, result, hold_r);
      chk({nm, "_bp_cout"}, W'(cout), W'(hold_c));
      chk({nm, "_bp_rdy"}, W'(in_ready), W'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, "_post_vld"}, W'(out_valid), W'(0));
    chk({nm, "_post_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #3;
    chk("rst_rdy", W'(in_ready), W'(1));
    chk("rst_vld", W'(out_valid), W'(0));
    chk("rst_res", result, '0);
    chk("rst_cout", W'(cout), W'(0));
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("t1", W'(1), W'(2), 1'b0, 0);
    run_op("t2", {W{1'b1}}, W'(1), 1'b0, 0);
    run_op("t3", W'(5), W'(7), 1'b1, 0);
    run_op("t4", {W{1'b1}}, {W{1'b1}}, 1'b1, 0);
    run_op("t5", W'(1), W'(2), 1'b0, 3);
    run_op("t5n", W'(5), W'(7), 1'b1, 0);

    // reset while limb1 is in its CINC pass
    in_valid = 1'b1;
    a = '1;
    b = W'(1);
    op_sub = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("t6_busy_rdy", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    chk("t6_rdy", W'(in_ready), W'(1));
    chk("t6_vld", W'(out_valid), W'(0));
    chk("t6_res", result, '0);
    chk("t6_cout", W'(cout), W'(0));
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("t6b", W'(3), W'(4), 1'b0, 0);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] rx, ry;
      rx = {$urandom, $urandom, $urandom, $urandom};
      ry = {$urandom, $urandom, $urandom, $urandom};
      run_op("rnd", rx, ry, i[0], 0);
    end

    chk("sb_empty", W'(sb.size()), W'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
